fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_if.sv | 33 +++
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch.sv | 148 ++++++++++++++
 tb/tb_fetch.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   OPCODE_ALU / OPCODE_ALUI : major opcodes for register and immediate ALU ops
//   NOP_INSTR                : canonical NOP (addi x0, x0, 0), emitted on bubbles
//   fetch_pair_t             : {pc, instruction} pair carried from fetch to decode
package riscv_pkg;

    localparam logic [6:0]  OPCODE_ALU  = 7'b0110011;
    localparam logic [6:0]  OPCODE_ALUI = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR   = {12'h000, 5'd0, 3'b000, 5'd0, OPCODE_ALUI};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory port between fetch (master) and memory (slave).
//   imem_req_valid / imem_req_ready / imem_req_addr : request channel
//   imem_resp_valid / imem_resp_data                : response channel
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1; the master keeps imem_req_addr stable while
// valid is high and may drop valid without a transfer only on redirect or
// reset. The response channel has no ready: the master always accepts a
// response, responses return in request order, at least one cycle after the
// request transfers.
interface fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empties the FIFO next cycle (overrides push/pop)
//   push, push_data : enqueue
//   pop, pop_data   : dequeue; pop_data is the current head
//   count           : occupancy 0..2
//   full, empty     : occupancy flags
// Push and pop in the same cycle are allowed, including when full.
module fetch_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; occupancy alone says what is meaningful.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = cnt;
    assign full     = (cnt == 2'd2);
    assign empty    = (cnt == 2'd0);

    a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
        !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset || flush)
        !(pop && empty));

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage.
//   clk, reset      : clock, synchronous active-high reset
//   stall           : decode not accepting; output registers hold
//   redirect_valid  : control-flow change; redirect_pc[31:2] is the new pc
//   imem            : instruction-memory port (fetch_if.master)
//   pc_out          : pc of the instruction presented to decode
//   instruction_out : instruction word (NOP on bubbles)
//   valid_out       : instruction_out is a real fetched instruction
//
// At most two instructions are in flight: outstanding requests plus buffered
// responses never exceed two, so neither the response buffer nor the pc tag
// queue can overflow. After a redirect, responses to older requests still
// arrive; drop_count discards exactly that many.
module fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    fetch_if.master     imem,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  drop_count;
    logic [1:0]  outstanding_next;
    logic [2:0]  occupancy;

    logic [1:0]  buf_count;
    logic        buf_full;
    logic        buf_empty;
    fetch_pair_t buf_head;
    fetch_pair_t resp_pair;

    logic [1:0]  tag_count;
    logic        tag_full;
    logic        tag_empty;
    logic [31:0] tag_head;

    logic        req_fire;
    logic        resp_live;
    logic        resp_drop;
    logic        buf_push;
    logic        buf_pop;

    // Low two bits of the redirect target are discarded by design.
    logic        unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign occupancy           = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem.imem_req_valid = !reset && !redirect_valid && (occupancy < 3'd2);
    assign imem.imem_req_addr  = fetch_pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    // Any response retires one outstanding request, live or dropped.
    assign resp_drop = imem.imem_resp_valid && (drop_count != 2'd0);
    assign resp_live = imem.imem_resp_valid && (drop_count == 2'd0) && !redirect_valid;
    assign outstanding_next = outstanding + {1'b0, req_fire} - {1'b0, imem.imem_resp_valid};

    assign resp_pair = {tag_head, imem.imem_resp_data};

    // A live response bypasses to the output only when nothing older is
    // waiting and decode is accepting; otherwise it queues.
    assign buf_push = resp_live && (stall || !buf_empty);
    assign buf_pop  = !redirect_valid && !stall && !buf_empty;

    fetch_buffer #(.W($bits(fetch_pair_t))) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data (resp_pair),
        .pop       (buf_pop),
        .pop_data  (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    fetch_buffer #(.W(32)) u_tag_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .pop_data  (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc        <= RESET_PC;
            outstanding     <= 2'd0;
            drop_count      <= 2'd0;
            pc_out          <= 32'h0000_0000;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc        <= {redirect_pc[31:2], 2'b00};
                // A response landing in this same cycle is already discarded.
                drop_count      <= outstanding - {1'b0, imem.imem_resp_valid};
                instruction_out <= NOP_INSTR;
                valid_out       <= 1'b0;
            end else begin
                if (req_fire)  fetch_pc   <= fetch_pc + 32'd4;
                if (resp_drop) drop_count <= drop_count - 2'd1;
                if (!stall) begin
                    if (!buf_empty) begin
                        pc_out          <= buf_head.pc;
                        instruction_out <= buf_head.instr;
                        valid_out       <= 1'b1;
                    end else if (resp_live) begin
                        pc_out          <= resp_pair.pc;
                        instruction_out <= resp_pair.instr;
                        valid_out       <= 1'b1;
                    end else begin
                        instruction_out <= NOP_INSTR;
                        valid_out       <= 1'b0;
                    end
                end
            end
        end
    end

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
        imem.imem_resp_valid |-> (outstanding != 2'd0));
    a_live_has_tag: assert property (@(posedge clk) disable iff (reset)
        resp_live |-> !tag_empty);
    a_tag_tracks_live: assert property (@(posedge clk) disable iff (reset)
        tag_count == (outstanding - drop_count));
    a_tag_room: assert property (@(posedge clk) disable iff (reset)
        req_fire |-> !tag_full);
    a_full_buffer_idle: assert property (@(posedge clk) disable iff (reset)
        buf_full |-> (outstanding == 2'd0));

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: in-order memory model with programmable latency,
// reference model of expected request addresses and decode outputs, and a
// negedge monitor that checks outputs against an expected queue.
module tb_fetch;
    import riscv_pkg::*;

    localparam int W = 64;

    typedef struct {
        logic [31:0] addr;
        int          issue_cyc;
        bit          dropped;
    } req_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    logic [31:0] w_pc_out;
    logic [31:0] w_instruction_out;
    logic        w_valid_out;
    logic        w_stall = 1'b0;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;

    fetch_if m_if ();
    fetch_if w_if ();

    fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem            (m_if),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk             (clk),
        .reset           (reset),
        .stall           (w_stall),
        .redirect_valid  (w_redirect_valid),
        .redirect_pc     (w_redirect_pc),
        .imem            (w_if),
        .pc_out          (w_pc_out),
        .instruction_out (w_instruction_out),
        .valid_out       (w_valid_out)
    );

    // ---------------- model state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w_exp_q[$];
    req_t        pend_q[$];
    logic [31:0] model_pc;
    int          cyc = 0;
    int          edge_cnt = 0;
    int          lat = 1;
    int          resp_pct = 100;
    int          phase = 0;
    int          reset_fall_edge = 0;
    int          drop_seen = 0;
    bit          want_first = 1'b0;
    logic [31:0] want_first_pc = 32'h0;

    logic [31:0] w_model_pc;
    logic [31:0] w_addr_prev = 32'h0;
    bit          w_fire_prev = 1'b0;
    int          w_idx = 0;
    logic [31:0] wrap_addrs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    logic        prev_valid = 1'b0;

    always @(posedge clk) edge_cnt++;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset) begin
            chk("reset_pc_out", {32'h0, pc_out}, 64'h0);
            chk("reset_instr", {32'h0, instruction_out}, {32'h0, NOP_INSTR});
            chk("reset_valid", {63'h0, valid_out}, 64'h0);
            chk("reset_req_valid", {63'h0, m_if.imem_req_valid}, 64'h0);
        end else if (redirect_valid) begin
            chk("redirect_bubble", {31'h0, valid_out, instruction_out}, {32'h0, NOP_INSTR});
            chk("redirect_pc_hold", {32'h0, pc_out}, {32'h0, prev_pc});
        end else if (stall) begin
            chk("stall_hold", {pc_out, instruction_out}, {prev_pc, prev_instr});
            chk("stall_hold_valid", {63'h0, valid_out}, {63'h0, prev_valid});
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual pc %h instr %h required no output", pc_out, instruction_out);
            end else begin
                e = exp_q.pop_front();
                chk("output_pair", {pc_out, instruction_out}, e);
                if (want_first) begin
                    chk("first_pc_after_redirect", {32'h0, pc_out}, {32'h0, want_first_pc});
                    want_first = 1'b0;
                end
            end
        end else begin
            chk("bubble_nop", {32'h0, instruction_out}, {32'h0, NOP_INSTR});
            chk("bubble_pc_hold", {32'h0, pc_out}, {32'h0, prev_pc});
            chk("missed_output", 64'(exp_q.size()), 64'h0);
        end

        if (phase == 1 && !reset) begin
            if (edge_cnt - reset_fall_edge == 1)
                chk("first_valid_latency", {63'h0, valid_out}, 64'h0);
            else if (edge_cnt - reset_fall_edge >= 2)
                chk("throughput", {63'h0, valid_out}, 64'h1);
        end

        if (!reset) begin
            if (w_valid_out) begin
                if (w_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrap_unexpected_output: actual pc %h required no output", w_pc_out);
                end else begin
                    e = w_exp_q.pop_front();
                    chk("wrap_output_pair", {w_pc_out, w_instruction_out}, e);
                end
            end else begin
                chk("wrap_missed_output", 64'(w_exp_q.size()), 64'h0);
            end
        end

        prev_pc    = pc_out;
        prev_instr = instruction_out;
        prev_valid = valid_out;
    end

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc, input bit rdy);
        req_t r;
        logic exp_rv;
        @(negedge clk);
        #2;
        cyc++;
        if (reset && !rst) reset_fall_edge = edge_cnt;
        reset          = rst;
        stall          = stl;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        m_if.imem_req_ready  = rdy;
        m_if.imem_resp_valid = 1'b0;
        m_if.imem_resp_data  = $urandom;
        w_if.imem_req_ready  = 1'b1;
        w_if.imem_resp_valid = 1'b0;
        w_if.imem_resp_data  = $urandom;

        // Two instructions may be in flight: requested-but-unanswered plus
        // answered-but-not-yet-delivered.
        exp_rv = !rst && !rdr && ((pend_q.size() + exp_q.size()) < 2);

        if (rst) begin
            pend_q.delete();
            exp_q.delete();
            model_pc = 32'h0000_0000;
            w_exp_q.delete();
            w_fire_prev = 1'b0;
            w_model_pc = 32'hFFFF_FFF8;
            w_idx = 0;
        end else begin
            if (rdr) begin
                foreach (pend_q[i]) pend_q[i].dropped = 1'b1;
                exp_q.delete();
                model_pc = rpc & ~32'h3;
            end
            if (pend_q.size() > 0 && cyc >= pend_q[0].issue_cyc + lat &&
                $urandom_range(0, 99) < resp_pct) begin
                r = pend_q.pop_front();
                m_if.imem_resp_valid = 1'b1;
                m_if.imem_resp_data  = mem_data(r.addr);
                if (r.dropped || rdr) drop_seen++;
                else exp_q.push_back({r.addr, mem_data(r.addr)});
            end
            if (w_fire_prev) begin
                w_if.imem_resp_valid = 1'b1;
                w_if.imem_resp_data  = mem_data(w_addr_prev);
                w_exp_q.push_back({w_addr_prev, mem_data(w_addr_prev)});
            end
        end

        #1;
        chk("req_valid", {63'h0, m_if.imem_req_valid}, {63'h0, exp_rv});
        if (m_if.imem_req_valid && rdy) begin
            chk("req_addr", {32'h0, m_if.imem_req_addr}, {32'h0, model_pc});
            pend_q.push_back('{addr: model_pc, issue_cyc: cyc, dropped: 1'b0});
            model_pc = model_pc + 32'd4;
        end

        w_fire_prev = 1'b0;
        if (!rst && w_if.imem_req_valid) begin
            chk("wrap_req_addr", {32'h0, w_if.imem_req_addr}, {32'h0, w_model_pc});
            if (w_idx < 3)
                chk("wrap_sequence", {32'h0, w_if.imem_req_addr}, {32'h0, wrap_addrs[w_idx]});
            w_idx++;
            w_addr_prev = w_if.imem_req_addr;
            w_fire_prev = 1'b1;
            w_model_pc  = w_model_pc + 32'd4;
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        m_if.imem_req_ready = 1'b1;
        m_if.imem_resp_valid = 1'b0;
        m_if.imem_resp_data = 32'h0;
        w_if.imem_req_ready = 1'b1;
        w_if.imem_resp_valid = 1'b0;
        w_if.imem_resp_data = 32'h0;
        model_pc = 32'h0;
        w_model_pc = 32'hFFFF_FFF8;

        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset start: 1-cycle memory, always ready.
        phase = 1;
        repeat (14) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Stall held for three cycles mid-stream.
        phase = 2;
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x100 with two requests outstanding.
        phase = 3;
        lat = 3;
        for (int i = 0; i < 20 && pend_q.size() < 2; i++)
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("redirect_outstanding", 64'(pend_q.size()), 64'd2);
        drop_seen = 0;
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        want_first = 1'b1;
        want_first_pc = 32'h0000_0100;
        repeat (14) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("dropped_responses", 64'(drop_seen), 64'd2);
        chk("first_pc_consumed", {63'h0, want_first}, 64'h0);

        // Misaligned redirect target.
        phase = 4;
        step(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("misaligned_redirect_addr", {32'h0, m_if.imem_req_addr}, 64'h0000_0200);
        repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure: toggling ready, 3-cycle latency, random stall/redirect.
        phase = 5;
        resp_pct = 70;
        for (int i = 0; i < 700; i++)
            step(1'b0, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
                 $urandom, 1'($urandom_range(0, 1)));

        // Mid-run reset, then 2-cycle latency random traffic.
        phase = 6;
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        lat = 2;
        for (int i = 0; i < 300; i++)
            step(1'b0, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 2,
                 $urandom, 1'($urandom_range(0, 3) != 0));

        // Drain.
        resp_pct = 100;
        repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
